unidade_busca_pc: RTL and testbench
===================================

// Module: unidade_busca_pc
// PURPOSE
//  Program-counter / fetch-control stage placed directly upstream of the instruction memory.
//  - Holds the PC, selects the next PC (sequential, branch, jump, jr) and drives the word address into instruction memory.
//  - Watches the returned instruction word for the halt word.
//  - Detects illegal fetch targets and counts retired fetches for the single-cycle MIPS core.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  MEM_WORDS  256            instruction memory depth in 32-bit words; legal PC < MEM_WORDS*4
//  HALT_WORD  32'h0000_000C  instruction encoding (syscall) that stops fetch
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   asynchronous reset, active low
//  en             in   1   1 = advance PC this cycle; 0 = stall (hold all state)
//  branch_taken   in   1   conditional branch resolved taken
//  branch_offset  in   32  sign-extended 16-bit immediate (word offset)
//  jump           in   1   J/JAL
//  jump_target    in   26  instr[25:0] of J/JAL
//  jr             in   1   JR
//  jr_addr        in   32  register-file rs value for JR
//  instrucao      in   32  instruction word returned by instruction memory for pc
//  pc             out  32  current PC; drives instruction memory addr
//  pc_plus4       out  32  pc + 4 (for JAL link), combinational
//  fetch_valid    out  1   1 while state == RUN
//  halted         out  1   1 while state == HALT
//  fault          out  1   1 while state == FAULT
//  fault_addr     out  32  rejected next-PC value, valid while fault=1
//  instr_count    out  32  number of PC advances since reset
// BEHAVIOUR
//  States: RUN, HALT, FAULT. Only rst_n leaves HALT or FAULT.
//  Reset (async, rst_n=0):
//   - pc=RESET_PC, state=RUN, instr_count=0, fault_addr=0
//   - fetch_valid=1, halted=0, fault=0, all effective immediately
//  Next-PC candidate, priority jr > jump > branch > sequential:
//   - jr:         jr_addr
//   - jump:       {pc_plus4[31:28], jump_target, 2'b00}
//   - branch:     pc_plus4 + (branch_offset << 2), mod 2^32
//   - sequential: pc_plus4, mod 2^32; 0xFFFF_FFFC wraps to 0
//  Illegal candidate: cand[1:0] != 0, or cand[31:2] >= MEM_WORDS.
//  RUN, en=1, instrucao == HALT_WORD:
//   - state -> HALT; pc unchanged (stays on halt word)
//   - control inputs ignored; instr_count unchanged
//  RUN, en=1, candidate illegal:
//   - state -> FAULT; fault_addr <= cand; pc unchanged; instr_count unchanged
//  RUN, en=1, otherwise: pc <= cand; instr_count <= instr_count+1 (wraps at 2^32).
//  RUN, en=0: nothing changes, including halt/fault detection (stall has priority).
//  HALT / FAULT: pc, instr_count, fault_addr frozen; en and control inputs ignored.
//  Latency: one clock from the control inputs to the new pc. pc_plus4 and the memory read are combinational in the same cycle.
//  rst_n asserted mid-cycle or during a stall aborts immediately; no pending update survives.
// TESTING
//  1. Reset, en=1, no control for 3 clks -> pc 0,4,8,C; instr_count=3; fetch_valid=1.
//  2. Branch:
//     - pc=0x10, branch_taken=1, branch_offset=-2 -> pc=0x0C next clk.
//     - jump_target=0x20 with branch_taken also 1 -> jump wins, pc=0x80.
//  3. Stall:
//     - pc=0x08, en=0 for 2 clks with jr=1 -> pc stays 0x08, count unchanged.
//     - en=1 -> pc=jr_addr.
//  4. Halt:
//     - instrucao=0x0000000C at pc=0x14, en=1 -> halted=1, fetch_valid=0, pc stays 0x14.
//     - Further jumps are ignored.
//  5. Fault:
//     - jr_addr=0x0000_0402 -> fault=1, fault_addr=0x402.
//     - jr_addr=0x400 (MEM_WORDS=256) -> fault=1, fault_addr=0x400.
//     - In both cases pc is held.
//  6. Reset during HALT or FAULT, rst_n low mid-cycle -> pc=RESET_PC, state RUN, count 0 without waiting for clk.

Source files
------------

// File: rtl/unidade_busca_pc_if.sv
// unidade_busca_pc_if
//   Groups the fetch-control inputs and the PC/status outputs of the
//   fetch stage into one bundle. Clock and reset are not part of it.
//   Inputs (core/imem -> fetch stage):
//     en_i, branch_taken_i, branch_offset_i, jump_i, jump_target_i,
//     jr_i, jr_addr_i, instrucao_i
//   Outputs (fetch stage -> core/imem):
//     pc_o, pc_plus4_o, fetch_valid_o, halted_o, fault_o, fault_addr_o,
//     instr_count_o
//   Modports: slave = fetch stage side, master = core/testbench side.
interface unidade_busca_pc_if;
  logic        en_i;
  logic        branch_taken_i;
  logic [31:0] branch_offset_i;
  logic        jump_i;
  logic [25:0] jump_target_i;
  logic        jr_i;
  logic [31:0] jr_addr_i;
  logic [31:0] instrucao_i;

  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fetch_valid_o;
  logic        halted_o;
  logic        fault_o;
  logic [31:0] fault_addr_o;
  logic [31:0] instr_count_o;

  modport slave (
    input  en_i, branch_taken_i, branch_offset_i, jump_i, jump_target_i,
           jr_i, jr_addr_i, instrucao_i,
    output pc_o, pc_plus4_o, fetch_valid_o, halted_o, fault_o,
           fault_addr_o, instr_count_o
  );

  modport master (
    output en_i, branch_taken_i, branch_offset_i, jump_i, jump_target_i,
           jr_i, jr_addr_i, instrucao_i,
    input  pc_o, pc_plus4_o, fetch_valid_o, halted_o, fault_o,
           fault_addr_o, instr_count_o
  );
endinterface

// File: rtl/unidade_busca_pc.sv
// unidade_busca_pc
//   Program-counter / fetch-control stage sitting in front of the
//   instruction memory of a single-cycle MIPS core. Holds the PC, picks
//   the next PC (jr > jump > branch > sequential), stops on the halt
//   word, traps on illegal fetch targets and counts PC advances.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous reset, active low
//     bus   - unidade_busca_pc_if.slave (control inputs, instruction word,
//             PC and status outputs)
//   Parameters:
//     RESET_PC  - PC value loaded on reset
//     MEM_WORDS - instruction memory depth in words; legal PC < MEM_WORDS*4
//     HALT_WORD - instruction encoding that stops fetch
module unidade_busca_pc #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
  input logic              clk,
  input logic              rst_n,
  unidade_busca_pc_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [31:0] MemWordsW = 32'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instrCount_q, instrCount_d;
  logic [31:0] faultAddr_q, faultAddr_d;

  logic [31:0] pcPlus4;
  logic [31:0] branchPc;
  logic [31:0] jumpPc;
  logic [31:0] candPc;
  logic        candIllegal;

  assign pcPlus4  = pc_q + 32'd4;
  assign branchPc = pcPlus4 + {bus.branch_offset_i[29:0], 2'b00};
  assign jumpPc   = {pcPlus4[31:28], bus.jump_target_i, 2'b00};

  always_comb begin
    candPc = pcPlus4;
    if (bus.jr_i) begin
      candPc = bus.jr_addr_i;
    end else if (bus.jump_i) begin
      candPc = jumpPc;
    end else if (bus.branch_taken_i) begin
      candPc = branchPc;
    end
  end

  // Misaligned targets and word indices past the end of memory both trap.
  assign candIllegal = (candPc[1:0] != 2'b00) ||
                       ({2'b00, candPc[31:2]} >= MemWordsW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      instrCount_q <= 32'd0;
      faultAddr_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instrCount_q <= instrCount_d;
      faultAddr_q  <= faultAddr_d;
    end
  end

  // Halt detection outranks the illegal-target check; a stall (en=0)
  // outranks both, so nothing is evaluated while stalled.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instrCount_d = instrCount_q;
    faultAddr_d  = faultAddr_q;
    if (state_q == ST_RUN && bus.en_i) begin
      if (bus.instrucao_i == HALT_WORD) begin
        state_d = ST_HALT;
      end else if (candIllegal) begin
        state_d     = ST_FAULT;
        faultAddr_d = candPc;
      end else begin
        pc_d         = candPc;
        instrCount_d = instrCount_q + 32'd1;
      end
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.pc_plus4_o    = pcPlus4;
  assign bus.fetch_valid_o = (state_q == ST_RUN);
  assign bus.halted_o      = (state_q == ST_HALT);
  assign bus.fault_o       = (state_q == ST_FAULT);
  assign bus.fault_addr_o  = faultAddr_q;
  assign bus.instr_count_o = instrCount_q;

endmodule

// File: tb/tb_unidade_busca_pc.sv
// tb_unidade_busca_pc
//   Self-checking bench for unidade_busca_pc: a table of directed vectors
//   walked in a loop, followed by hand-written halt, fault and
//   asynchronous-reset sequences.
module tb_unidade_busca_pc;

  typedef struct {
    logic        en;
    logic        br;
    logic [31:0] off;
    logic        jmp;
    logic [25:0] tgt;
    logic        jr;
    logic [31:0] jrAddr;
    logic [31:0] instr;
    logic [31:0] expPc;
    logic [31:0] expCnt;
    logic [2:0]  expFlags;   // {fetch_valid, halted, fault}
    logic [31:0] expFa;
  } vec_t;

  localparam int NumVecs = 15;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   failCount;
  vec_t vecs [NumVecs];

  unidade_busca_pc_if busIf ();

  unidade_busca_pc #(
    .RESET_PC (32'h0000_0000),
    .MEM_WORDS(256),
    .HALT_WORD(32'h0000_000C)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t makeVec(
    input logic en, input logic br, input logic [31:0] off,
    input logic jmp, input logic [25:0] tgt, input logic jr,
    input logic [31:0] jrAddr, input logic [31:0] instr,
    input logic [31:0] expPc, input logic [31:0] expCnt,
    input logic [2:0] expFlags, input logic [31:0] expFa);
    vec_t v;
    v.en = en; v.br = br; v.off = off; v.jmp = jmp; v.tgt = tgt;
    v.jr = jr; v.jrAddr = jrAddr; v.instr = instr;
    v.expPc = expPc; v.expCnt = expCnt; v.expFlags = expFlags;
    v.expFa = expFa;
    return v;
  endfunction

  task automatic setInputs(input vec_t v);
    busIf.en_i            = v.en;
    busIf.branch_taken_i  = v.br;
    busIf.branch_offset_i = v.off;
    busIf.jump_i          = v.jmp;
    busIf.jump_target_i   = v.tgt;
    busIf.jr_i            = v.jr;
    busIf.jr_addr_i       = v.jrAddr;
    busIf.instrucao_i     = v.instr;
  endtask

  // Drive one vector, let one rising edge act on it, sample 1ns later.
  task automatic applyStimulus(input vec_t v);
    setInputs(v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] expPc,
                          input logic [31:0] expCnt, input logic [2:0] flags,
                          input logic [31:0] expFa);
    checkOutput({tag, " pc"},          busIf.pc_o, expPc);
    checkOutput({tag, " pc_plus4"},    busIf.pc_plus4_o, expPc + 32'd4);
    checkOutput({tag, " instr_count"}, busIf.instr_count_o, expCnt);
    checkOutput({tag, " fetch_valid"}, {31'd0, busIf.fetch_valid_o}, {31'd0, flags[2]});
    checkOutput({tag, " halted"},      {31'd0, busIf.halted_o}, {31'd0, flags[1]});
    checkOutput({tag, " fault"},       {31'd0, busIf.fault_o}, {31'd0, flags[0]});
    checkOutput({tag, " fault_addr"},  busIf.fault_addr_o, expFa);
  endtask

  // Pull rst_n low between clock edges and check the reset state before
  // any further edge arrives, then release on a falling edge.
  task automatic midCycleReset(input string tag);
    setInputs(makeVec(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 32'd0,
                      32'd0, 32'd0, 3'b100, 32'd0));
    #2;
    rst_n = 1'b0;
    #1;
    checkAll(tag, 32'h0, 32'd0, 3'b100, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [31:0] HaltW = 32'h0000_000C;

  initial begin
    testsRun  = 0;
    failCount = 0;
    rst_n     = 1'b0;

    //            en br off           jmp tgt       jr jrAddr        instr   expPc         cnt  flags   fa
    vecs[0]  = makeVec(1, 0, 32'd0,        0, 26'd0,    0, 32'd0,        32'd0, 32'h04,  32'd1,  3'b100, 32'd0);
    vecs[1]  = makeVec(1, 0, 32'd0,        0, 26'd0,    0, 32'd0,        32'd0, 32'h08,  32'd2,  3'b100, 32'd0);
    vecs[2]  = makeVec(1, 0, 32'd0,        0, 26'd0,    0, 32'd0,        32'd0, 32'h0C,  32'd3,  3'b100, 32'd0);
    vecs[3]  = makeVec(1, 0, 32'd0,        0, 26'd0,    0, 32'd0,        32'd0, 32'h10,  32'd4,  3'b100, 32'd0);
    // Backward branch: 0x14 + (-2 << 2) = 0x0C
    vecs[4]  = makeVec(1, 1, 32'hFFFF_FFFE, 0, 26'd0,   0, 32'd0,        32'd0, 32'h0C,  32'd5,  3'b100, 32'd0);
    // Jump beats branch: {0, 0x20, 00} = 0x80
    vecs[5]  = makeVec(1, 1, 32'd5,        1, 26'h20,   0, 32'd0,        32'd0, 32'h80,  32'd6,  3'b100, 32'd0);
    // JR beats jump
    vecs[6]  = makeVec(1, 0, 32'd0,        1, 26'h30,   1, 32'h08,       32'd0, 32'h08,  32'd7,  3'b100, 32'd0);
    // Stall for two clocks with a pending JR
    vecs[7]  = makeVec(0, 0, 32'd0,        0, 26'd0,    1, 32'h40,       32'd0, 32'h08,  32'd7,  3'b100, 32'd0);
    vecs[8]  = makeVec(0, 0, 32'd0,        0, 26'd0,    1, 32'h40,       32'd0, 32'h08,  32'd7,  3'b100, 32'd0);
    vecs[9]  = makeVec(1, 0, 32'd0,        0, 26'd0,    1, 32'h40,       32'd0, 32'h40,  32'd8,  3'b100, 32'd0);
    // Stall masks both the halt word and an illegal target
    vecs[10] = makeVec(0, 0, 32'd0,        0, 26'd0,    0, 32'd0,        HaltW, 32'h40,  32'd8,  3'b100, 32'd0);
    vecs[11] = makeVec(0, 0, 32'd0,        0, 26'd0,    1, 32'h402,      32'd0, 32'h40,  32'd8,  3'b100, 32'd0);
    // Forward branch: 0x44 + (0x10 << 2) = 0x84
    vecs[12] = makeVec(1, 1, 32'h10,       0, 26'd0,    0, 32'd0,        32'd0, 32'h84,  32'd9,  3'b100, 32'd0);
    // Last legal word, then sequential step off the end of memory
    vecs[13] = makeVec(1, 0, 32'd0,        0, 26'd0,    1, 32'h3FC,      32'd0, 32'h3FC, 32'd10, 3'b100, 32'd0);
    vecs[14] = makeVec(1, 0, 32'd0,        0, 26'd0,    0, 32'd0,        32'd0, 32'h3FC, 32'd10, 3'b001, 32'h400);

    setInputs(makeVec(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 32'd0,
                      32'd0, 32'd0, 3'b100, 32'd0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkAll("reset", 32'h0, 32'd0, 3'b100, 32'h0);

    for (int i = 0; i < NumVecs; i++) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expCnt,
               vecs[i].expFlags, vecs[i].expFa);
    end

    // FAULT is sticky against further control activity
    applyStimulus(makeVec(1, 0, 32'd0, 1, 26'h04, 0, 32'd0, 32'd0,
                          32'd0, 32'd0, 3'b001, 32'd0));
    checkAll("faultHold", 32'h3FC, 32'd10, 3'b001, 32'h400);

    midCycleReset("rstFromFault");

    // Halt: advance to 0x14, then present the halt word there
    for (int i = 0; i < 5; i++) begin
      applyStimulus(makeVec(1, 0, 32'd0, 0, 26'd0, 0, 32'd0, 32'd0,
                            32'd0, 32'd0, 3'b100, 32'd0));
    end
    checkAll("preHalt", 32'h14, 32'd5, 3'b100, 32'h0);
    applyStimulus(makeVec(1, 0, 32'd0, 1, 26'h08, 0, 32'd0, HaltW,
                          32'd0, 32'd0, 3'b010, 32'd0));
    checkAll("halt", 32'h14, 32'd5, 3'b010, 32'h0);
    applyStimulus(makeVec(1, 0, 32'd0, 1, 26'h08, 0, 32'd0, 32'd0,
                          32'd0, 32'd0, 3'b010, 32'd0));
    checkAll("haltHold", 32'h14, 32'd5, 3'b010, 32'h0);

    midCycleReset("rstFromHalt");

    // Misaligned JR target from the reset PC
    applyStimulus(makeVec(1, 0, 32'd0, 0, 26'd0, 1, 32'h402, 32'd0,
                          32'd0, 32'd0, 3'b001, 32'd0));
    checkAll("faultMisaligned", 32'h0, 32'd0, 3'b001, 32'h402);
    applyStimulus(makeVec(1, 0, 32'd0, 0, 26'd0, 1, 32'h10, 32'd0,
                          32'd0, 32'd0, 3'b001, 32'd0));
    checkAll("faultMisalignedHold", 32'h0, 32'd0, 3'b001, 32'h402);

    midCycleReset("rstAfterMisaligned");

    // Reset during a stall with a pending JR leaves nothing behind
    applyStimulus(makeVec(1, 0, 32'd0, 0, 26'd0, 0, 32'd0, 32'd0,
                          32'd0, 32'd0, 3'b100, 32'd0));
    applyStimulus(makeVec(0, 0, 32'd0, 0, 26'd0, 1, 32'h200, 32'd0,
                          32'd0, 32'd0, 3'b100, 32'd0));
    checkAll("stallBeforeReset", 32'h4, 32'd1, 3'b100, 32'h0);
    midCycleReset("rstDuringStall");
    applyStimulus(makeVec(1, 0, 32'd0, 0, 26'd0, 0, 32'd0, 32'd0,
                          32'd0, 32'd0, 3'b100, 32'd0));
    checkAll("afterStallReset", 32'h4, 32'd1, 3'b100, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
